// File: rtl/mdu_pkg.sv
// mdu_pkg: op codes and issue-FSM state type shared by mdu_issue and the MDU.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mdu_pkg;

  // funct3 encodings of the M extension; the MDU decodes the same values
  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } mdu_issue_state_t;

  // all divide/remainder ops have funct3[2] set
  function automatic logic is_div_group(input logic [2:0] op);
    return op[2];
  endfunction

endpackage

// File: rtl/mdu_issue.sv
// mdu_issue: accepts one M-extension op from EX, issues it to the MDU, returns the result to write-back.
// Latency: accept at T, MDU request pulse at T+1, wb_valid_o the cycle after mdu_ready_i (T+1 on zero-divisor fast path).
// Backpressure: stall_o freezes the pipeline through EX while a request is outstanding or draining; one op in flight.
// Optional feature: `define MDU_ZERO_FASTPATH_EN resolves divide/remainder by zero locally without the MDU.
module mdu_issue
  import mdu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid_i,
  input  logic [2:0]  ex_op_i,
  input  logic [31:0] ex_rs1_i,
  input  logic [31:0] ex_rs2_i,
  input  logic [4:0]  ex_rd_addr_i,
  input  logic        flush_i,
  output logic        stall_o,
  output logic        wb_valid_o,
  output logic [31:0] wb_data_o,
  output logic [4:0]  wb_rd_addr_o,
  output logic        mdu_valid_o,
  output logic [2:0]  mdu_op_o,
  output logic [31:0] mdu_rs1_o,
  output logic [31:0] mdu_rs2_o,
  input  logic        mdu_ready_i,
  input  logic [31:0] mdu_rd_i
);

  mdu_issue_state_t r_state;
  mdu_issue_state_t w_state_nxt;

  logic [2:0]  r_op;
  logic [31:0] r_rs1;
  logic [31:0] r_rs2;
  logic [4:0]  r_rd;
  logic [31:0] r_wb_data;

  logic        w_accept;
  logic        w_fast;
  logic [31:0] w_fast_data;
  logic        w_stall;
  logic        w_mdu_valid;
  logic        w_wb_valid;

  // reset has priority, so nothing is accepted while it is asserted
  assign w_accept = !rst && (r_state == S_IDLE) && ex_valid_i && !flush_i;

`ifdef MDU_ZERO_FASTPATH_EN
  // divide by zero has an architecturally fixed result; no need to occupy the MDU
  assign w_fast = is_div_group(ex_op_i) && (ex_rs2_i == 32'd0);
  always_comb begin
    w_fast_data = 32'hFFFF_FFFF;
    case (ex_op_i)
      OP_REM, OP_REMU: w_fast_data = ex_rs1_i;
      default:         w_fast_data = 32'hFFFF_FFFF;
    endcase
  end
`else
  assign w_fast      = 1'b0;
  assign w_fast_data = 32'd0;
`endif

  // next-state and strobes; the MDU cannot be aborted, so a flush after issue must drain
  always_comb begin
    w_state_nxt = r_state;
    w_stall     = 1'b0;
    w_mdu_valid = 1'b0;
    w_wb_valid  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_stall     = 1'b1;
          w_state_nxt = w_fast ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_stall     = 1'b1;
        w_mdu_valid = 1'b1;
        w_state_nxt = flush_i ? S_DRAIN : S_WAIT;
      end
      S_WAIT: begin
        w_stall = 1'b1;
        if (flush_i) begin
          w_state_nxt = mdu_ready_i ? S_IDLE : S_DRAIN;
        end else if (mdu_ready_i) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DRAIN: begin
        w_stall = 1'b1;
        if (mdu_ready_i) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_DONE: begin
        w_wb_valid  = !flush_i;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // operand latch at acceptance, held unchanged until the next acceptance; result capture
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op      <= 3'd0;
      r_rs1     <= 32'd0;
      r_rs2     <= 32'd0;
      r_rd      <= 5'd0;
      r_wb_data <= 32'd0;
    end else begin
      if (w_accept) begin
        r_op  <= ex_op_i;
        r_rs1 <= ex_rs1_i;
        r_rs2 <= ex_rs2_i;
        r_rd  <= ex_rd_addr_i;
      end
      if (w_accept && w_fast) begin
        r_wb_data <= w_fast_data;
      end else if ((r_state == S_WAIT) && mdu_ready_i && !flush_i) begin
        r_wb_data <= mdu_rd_i;
      end
    end
  end

  assign stall_o      = w_stall;
  assign wb_valid_o   = w_wb_valid;
  assign wb_data_o    = r_wb_data;
  assign wb_rd_addr_o = r_rd;
  assign mdu_valid_o  = w_mdu_valid;
  assign mdu_op_o     = r_op;
  assign mdu_rs1_o    = r_rs1;
  assign mdu_rs2_o    = r_rs2;

endmodule

// File: tb/tb_mdu_issue.sv
// tb_mdu_issue: directed vector table, flush/reset sequences and random ops against a reference model.
// Latency: the bench's MDU answers 3 cycles after the request for MUL ops and 34 for DIV ops.
// Backpressure: the EX instruction is held while stall_o is high, as a frozen pipeline would.
module tb_mdu_issue;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid_i;
  logic [2:0]  ex_op_i;
  logic [31:0] ex_rs1_i;
  logic [31:0] ex_rs2_i;
  logic [4:0]  ex_rd_addr_i;
  logic        flush_i;
  logic        stall_o;
  logic        wb_valid_o;
  logic [31:0] wb_data_o;
  logic [4:0]  wb_rd_addr_o;
  logic        mdu_valid_o;
  logic [2:0]  mdu_op_o;
  logic [31:0] mdu_rs1_o;
  logic [31:0] mdu_rs2_o;
  logic        mdu_ready_i;
  logic [31:0] mdu_rd_i;

  mdu_issue dut (
    .clk(clk), .rst(rst),
    .ex_valid_i(ex_valid_i), .ex_op_i(ex_op_i), .ex_rs1_i(ex_rs1_i), .ex_rs2_i(ex_rs2_i),
    .ex_rd_addr_i(ex_rd_addr_i), .flush_i(flush_i), .stall_o(stall_o),
    .wb_valid_o(wb_valid_o), .wb_data_o(wb_data_o), .wb_rd_addr_o(wb_rd_addr_o),
    .mdu_valid_o(mdu_valid_o), .mdu_op_o(mdu_op_o), .mdu_rs1_o(mdu_rs1_o), .mdu_rs2_o(mdu_rs2_o),
    .mdu_ready_i(mdu_ready_i), .mdu_rd_i(mdu_rd_i)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int stab_err = 0;
  int op_p0;
  int op_s0;

`ifdef MDU_ZERO_FASTPATH_EN
  localparam int DIV0_LAT = 1;
`else
  localparam int DIV0_LAT = 36;
`endif

  // architectural M-extension results
  function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, sp;
    longint unsigned ua, ub, up;
    int ia, ib;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    ia = a;
    ib = b;
    case (op)
      3'd0: begin sp = sa * sb; return sp[31:0]; end
      3'd1: begin sp = sa * sb; return sp[63:32]; end
      3'd2: begin sp = sa * longint'(ub); return sp[63:32]; end
      3'd3: begin up = ua * ub; return up[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return ia / ib;
      end
      3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return ia % ib;
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  // acceptance-to-write-back distance in cycles
  function automatic int ref_lat(input logic [2:0] op, input logic [31:0] b);
    if (!op[2]) return 5;
    if (b == 32'd0) return DIV0_LAT;
    return 36;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // behavioural MDU: takes a request pulse, answers after a fixed delay, checks operands stay put
  logic        m_pend;
  int          m_cnt;
  logic [2:0]  m_op;
  logic [31:0] m_a, m_b;
  initial begin
    m_pend = 1'b0; m_cnt = 0; m_op = 3'd0; m_a = 32'd0; m_b = 32'd0;
    mdu_ready_i = 1'b0; mdu_rd_i = 32'd0;
    forever begin
      @(negedge clk);
      if ((m_pend || mdu_ready_i) &&
          (mdu_op_o !== m_op || mdu_rs1_o !== m_a || mdu_rs2_o !== m_b)) stab_err++;
      if (mdu_valid_o === 1'b1) begin
        pulses++;
        if (!m_pend) begin
          m_pend = 1'b1; m_op = mdu_op_o; m_a = mdu_rs1_o; m_b = mdu_rs2_o;
          m_cnt = m_op[2] ? 34 : 3;
        end
      end
      @(posedge clk);
      #1;
      mdu_ready_i = 1'b0;
      if (rst) begin
        m_pend = 1'b0;
      end else if (m_pend) begin
        m_cnt--;
        if (m_cnt == 0) begin
          mdu_ready_i = 1'b1;
          mdu_rd_i    = ref_res(m_op, m_a, m_b);
          m_pend      = 1'b0;
        end
      end
    end
  end

  // present an op in EX (caller sits just after a falling edge, state IDLE)
  task automatic start(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    op_p0 = pulses;
    op_s0 = stab_err;
    ex_valid_i = 1'b1; ex_op_i = op; ex_rs1_i = a; ex_rs2_i = b; ex_rd_addr_i = rd;
    #1;
    chk("accept_stall", stall_o, 1);
  endtask

  // follow the accepted op cycle by cycle until write-back
  task automatic wait_wb(input string tag, input int lat, input logic [31:0] exp, input logic [4:0] rd);
    int bad_stall = 0;
    int bad_vld = 0;
    bit seen = 0;
    for (int k = 1; k <= 60 && !seen; k++) begin
      @(negedge clk); #1;
      if (k < lat && stall_o !== 1'b1) bad_stall++;
      if (mdu_valid_o !== ((k == 1 && lat > 1) ? 1'b1 : 1'b0)) bad_vld++;
      if (wb_valid_o === 1'b1) begin
        seen = 1;
        chk({tag, ".lat"}, k, lat);
        chk({tag, ".data"}, wb_data_o, exp);
        chk({tag, ".rd"}, wb_rd_addr_o, rd);
        chk({tag, ".done_stall"}, stall_o, 0);
      end
    end
    chk({tag, ".wb_seen"}, seen, 1);
    chk({tag, ".stall_prof"}, bad_stall, 0);
    chk({tag, ".mdu_vld_prof"}, bad_vld, 0);
    chk({tag, ".pulses"}, pulses - op_p0, (lat > 1) ? 1 : 0);
    chk({tag, ".op_stable"}, stab_err - op_s0, 0);
    // EX still holds the instruction across the DONE edge; it must not be re-issued
    @(negedge clk); #1;
    ex_valid_i = 1'b0;
  endtask

  // flush at cycle fk after acceptance; the MDU answers in cycle rk and is discarded
  task automatic flush_seq(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input int fk, input int rk);
    int bad_stall = 0;
    int wbs = 0;
    start(op, a, b, 5'd9);
    for (int k = 1; k <= rk + 1; k++) begin
      @(negedge clk); #1;
      if (stall_o !== ((k <= rk) ? 1'b1 : 1'b0)) bad_stall++;
      if (wb_valid_o === 1'b1) wbs++;
      if (k == fk) begin flush_i = 1'b1; ex_valid_i = 1'b0; end
      if (k == fk + 1) flush_i = 1'b0;
    end
    chk({tag, ".stall_prof"}, bad_stall, 0);
    chk({tag, ".no_wb"}, wbs, 0);
    chk({tag, ".pulses"}, pulses - op_p0, 1);
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t        tbl[14];
  logic [2:0]  r_op;
  logic [31:0] r_a, r_b;
  logic [4:0]  r_rd;

  initial begin
    tbl[0]  = '{3'd0, 32'd7,         32'hFFFF_FFFD, 5'd3,  32'hFFFF_FFEB, 5};
    tbl[1]  = '{3'd5, 32'd100,       32'd7,         5'd4,  32'd14,        36};
    tbl[2]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5,  32'hFFFF_FFFE, 5};
    tbl[3]  = '{3'd4, 32'd5,         32'd0,         5'd6,  32'hFFFF_FFFF, DIV0_LAT};
    tbl[4]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 5'd7,  32'h4000_0000, 5};
    tbl[5]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8,  32'hFFFF_FFFF, 5};
    tbl[6]  = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9,  32'h8000_0000, 36};
    tbl[7]  = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'd0,         36};
    tbl[8]  = '{3'd6, 32'hFFFF_FFF9, 32'd2,         5'd11, 32'hFFFF_FFFF, 36};
    tbl[9]  = '{3'd7, 32'd9,         32'd0,         5'd12, 32'd9,         DIV0_LAT};
    tbl[10] = '{3'd5, 32'd9,         32'd0,         5'd13, 32'hFFFF_FFFF, DIV0_LAT};
    tbl[11] = '{3'd4, 32'hFFFF_FFF9, 32'd2,         5'd31, 32'hFFFF_FFFD, 36};
    tbl[12] = '{3'd6, 32'd9,         32'd0,         5'd1,  32'd9,         DIV0_LAT};
    tbl[13] = '{3'd0, 32'h1234_5678, 32'h10,        5'd0,  32'h2345_6780, 5};

    // reset dominates a valid EX op
    rst = 1'b1; flush_i = 1'b0;
    ex_valid_i = 1'b1; ex_op_i = 3'd5; ex_rs1_i = 32'hDEAD; ex_rs2_i = 32'hBEEF; ex_rd_addr_i = 5'd17;
    repeat (3) @(negedge clk);
    #1;
    chk("rst.mdu_valid", mdu_valid_o, 0);
    chk("rst.wb_valid", wb_valid_o, 0);
    chk("rst.mdu_op", mdu_op_o, 0);
    chk("rst.mdu_rs1", mdu_rs1_o, 0);
    chk("rst.wb_rd", wb_rd_addr_o, 0);
    chk("rst.wb_data", wb_data_o, 0);
    ex_valid_i = 1'b0; rst = 1'b0;
    @(negedge clk); #1;
    chk("rst.idle_stall", stall_o, 0);

    for (int i = 0; i < 14; i++) begin
      start(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].rd);
      wait_wb($sformatf("vec%0d", i), tbl[i].lat, tbl[i].exp, tbl[i].rd);
    end

    // flush in IDLE blocks acceptance
    ex_valid_i = 1'b1; ex_op_i = 3'd0; ex_rs1_i = 32'd3; ex_rs2_i = 32'd3; flush_i = 1'b1;
    #1;
    chk("idle_flush.stall", stall_o, 0);
    op_p0 = pulses;
    @(negedge clk); #1;
    ex_valid_i = 1'b0; flush_i = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("idle_flush.no_issue", pulses - op_p0, 0);

    // DIVU flushed at T+10 drains until T+35, then a MUL is accepted at T+36
    flush_seq("div_flush", 3'd5, 32'd100, 32'd7, 10, 35);
    start(3'd0, 32'd6, 32'd7, 5'd21);
    wait_wb("after_drain", 5, 32'd42, 5'd21);

    // flush while in ISSUE: request already pulsed, must still drain
    flush_seq("issue_flush", 3'd1, 32'd5, 32'd5, 1, 4);
    // flush together with the completion pulse: straight back to IDLE
    flush_seq("ready_flush", 3'd0, 32'd5, 32'd5, 4, 4);
    start(3'd0, 32'd11, 32'd3, 5'd22);
    wait_wb("after_rflush", 5, 32'd33, 5'd22);

    // flush in DONE suppresses the write-back strobe
    start(3'd0, 32'd3, 32'd4, 5'd2);
    repeat (4) @(negedge clk);
    @(negedge clk);
    flush_i = 1'b1;
    #1;
    chk("done_flush.wb", wb_valid_o, 0);
    ex_valid_i = 1'b0;
    @(negedge clk); #1;
    flush_i = 1'b0;
    chk("done_flush.idle_stall", stall_o, 0);
    chk("done_flush.wb_after", wb_valid_o, 0);

    // reset in the middle of a DIV
    start(3'd4, 32'd50, 32'd3, 5'd14);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk); #1;
      if (k == 3) begin rst = 1'b1; ex_valid_i = 1'b0; end
    end
    @(negedge clk); #1;
    rst = 1'b0;
    #1;
    chk("midrst.stall", stall_o, 0);
    chk("midrst.wb_valid", wb_valid_o, 0);
    chk("midrst.wb_data", wb_data_o, 0);
    chk("midrst.wb_rd", wb_rd_addr_o, 0);
    chk("midrst.mdu_valid", mdu_valid_o, 0);
    chk("midrst.mdu_op", mdu_op_o, 0);
    chk("midrst.mdu_rs1", mdu_rs1_o, 0);
    chk("midrst.mdu_rs2", mdu_rs2_o, 0);
    start(3'd0, 32'd9, 32'd9, 5'd23);
    wait_wb("after_rst", 5, 32'd81, 5'd23);

    // random ops, expectations from the architectural model
    for (int n = 0; n < 30; n++) begin
      r_op = 3'($urandom_range(0, 7));
      r_a  = $urandom;
      r_b  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      r_rd = 5'($urandom_range(0, 31));
      start(r_op, r_a, r_b, r_rd);
      wait_wb($sformatf("rnd%0d", n), ref_lat(r_op, r_b), ref_res(r_op, r_a, r_b), r_rd);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdu_issue.md
MDU_ISSUE -- requirements
Module: mdu_issue

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 ex_valid_i  input  1  EX stage holds an M-extension instruction.
REQ-004 ex_op_i  input  3  funct3 op code (MUL=000, MULH=001, MULHSU=010, MULHU=011, DIV=100, DIVU=101, REM=110, REMU=111).
REQ-005 ex_rs1_i / ex_rs2_i  input  32 each  source operands.
REQ-006 ex_rd_addr_i  input  5  destination register index.
REQ-007 flush_i  input  1  pipeline flush; kills the in-flight instruction.
REQ-008 stall_o  output  1  freezes the pipeline up to and including EX.
REQ-009 wb_valid_o  output  1  one-cycle write-back strobe.
REQ-010 wb_data_o  output  32  result.
REQ-011 wb_rd_addr_o  output  5  destination index for the result.
REQ-012 mdu_valid_o  output  1  request to the MDU; always a single-cycle pulse.
REQ-013 mdu_op_o  output  3  op code to the MDU.
REQ-014 mdu_rs1_o / mdu_rs2_o  output  32 each  operands to the MDU.
REQ-015 mdu_ready_i  input  1  MDU completion pulse.
REQ-016 mdu_rd_i  input  32  MDU result; valid in the cycle mdu_ready_i is high.

Function
REQ-017 FSM states: IDLE, ISSUE, WAIT, DRAIN, DONE.
REQ-018 IDLE: when ex_valid_i && !flush_i at cycle T, latch op, rs1, rs2 and rd_addr; next state is ISSUE.
REQ-019 ISSUE (T+1): mdu_valid_o=1 for exactly this cycle; next state is WAIT.
REQ-020 mdu_op_o, mdu_rs1_o and mdu_rs2_o are driven from the latched registers and held stable from ISSUE through the mdu_ready_i cycle inclusive.
REQ-021 WAIT: on mdu_ready_i, register mdu_rd_i into wb_data_o; next state is DONE.
REQ-022 mdu_ready_i is ignored in IDLE, ISSUE and DONE.
REQ-023 DONE: wb_valid_o=1 for one cycle with the latched rd_addr; stall_o=0; ex_valid_i is ignored; next state is IDLE.
REQ-024 stall_o is combinational: (IDLE && ex_valid_i && !flush_i) || ISSUE || WAIT || DRAIN.
REQ-025 Latency with the team MDU, measured from acceptance at T to the wb_valid_o cycle:
- MUL group: wb_valid_o at T+5.
- DIV group: wb_valid_o at T+36.
REQ-026 flush_i in ISSUE or WAIT moves the FSM to DRAIN. The MDU is not abortable, so mdu_valid_o is not retracted if already pulsed.
REQ-027 DRAIN: wait for mdu_ready_i, discard the result, return to IDLE; no wb_valid_o is produced.
REQ-028 flush_i in DONE suppresses wb_valid_o.
REQ-029 flush_i in IDLE blocks acceptance.
REQ-030 A flush and mdu_ready_i in the same WAIT cycle result in a discard and a transition to IDLE.
REQ-031 Exactly one request is outstanding at a time; no back-to-back issue before DONE or DRAIN completes.

Reset
REQ-032 rst=1 forces IDLE and clears all outputs and operand registers to 0; it takes priority over every other input.
REQ-033 Reset mid-operation: the MDU shares the same reset (inverted at the parent), so no drain is needed.

Configuration
REQ-034 Macro MDU_ZERO_FASTPATH_EN, when defined: a DIV/DIVU/REM/REMU accepted with rs2==0 skips the MDU. It goes from IDLE directly to DONE, so wb_valid_o is at T+1 and mdu_valid_o is never asserted. Results:
- DIV/DIVU: 0xFFFFFFFF.
- REM/REMU: rs1.
REQ-035 Macro MDU_ZERO_FASTPATH_EN, when undefined: all division ops, including rs2==0, go through ISSUE and WAIT.

Structure
REQ-036 Shared package mdu_pkg holds the op-code localparams (or enum) and the mdu_issue_state_t typedef; the MDU shares the same op codes.
REQ-037 No sub-module: the fast-path mux is inline, and the MDU is instantiated by the parent alongside mdu_issue.

Verification
REQ-038 MUL rs1=7, rs2=0xFFFFFFFD at T: mdu_valid_o at T+1 only; wb_valid_o at T+5 with wb_data_o=0xFFFFFFEB and the correct rd; stall_o high T..T+4.
REQ-039 DIVU rs1=100, rs2=7: wb_data_o=14 at T+36; mdu_op_o stable throughout.
REQ-040 MULHU rs1=rs2=0xFFFFFFFF: wb_data_o=0xFFFFFFFE at T+5.
REQ-041 With MDU_ZERO_FASTPATH_EN, DIV rs1=5, rs2=0: wb_valid_o at T+1, data=0xFFFFFFFF, mdu_valid_o never asserted. Without the macro: result comes from the MDU at T+36.
REQ-042 DIVU started, flush_i at T+10: no wb_valid_o; stall_o stays high until the mdu_ready_i cycle (T+35); a new MUL is accepted at T+36.
REQ-043 rst asserted at T+3 of a DIV: all outputs 0 next cycle, state IDLE, and a subsequent MUL completes normally.
